// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: requester, adder and response signals of the shared-adder arbiter
//   req0_*/req1_* : valid/a/b/last from requesters, ready back to them
//   add_*         : operands/carry-in to the external adder, sum/carry-out back
//   rsp_*         : registered one-cycle response stream
interface adder_share_arbiter_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_last;
  logic             req1_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_last;
  logic             rsp_err;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_last,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_last,
    output req1_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, rsp_err
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_last,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_last,
    input  req1_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, rsp_err
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin share of one 8-bit adder, chaining carry across multi-beat transactions
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of adder_share_arbiter_if (requesters, adder, response stream)
module adder_share_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  adder_share_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOCK} state_t;
  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);
  state_t           state, state_n;
  logic             owner, carry_reg, rr_ptr;
  logic [7:0]       beat_cnt;
  logic             sel, sel_valid, sel_last, go, acc, forced, term;
  logic [WIDTH-1:0] sel_a, sel_b;
  // In LOCK the owner is fixed; in IDLE a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    sel       = state == LOCK ? owner : (bus.req0_valid && bus.req1_valid ? rr_ptr : bus.req1_valid);
    sel_valid = sel ? bus.req1_valid : bus.req0_valid;
    sel_last  = sel ? bus.req1_last : bus.req0_last;
    sel_a     = sel_valid ? (sel ? bus.req1_a : bus.req0_a) : '0;
    sel_b     = sel_valid ? (sel ? bus.req1_b : bus.req0_b) : '0;
    go        = rst_n && (state == LOCK || sel_valid);
    acc       = rst_n && sel_valid;
    forced    = beat_cnt == LAST_CNT;
    term      = sel_last || forced;
    state_n   = acc ? (term ? IDLE : LOCK) : state;
    bus.req0_ready = go && !sel;
    bus.req1_ready = go && sel;
    bus.add_a      = sel_a;
    bus.add_b      = sel_b;
    bus.add_cin    = carry_reg;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner         <= 1'b0;
      carry_reg     <= 1'b0;
      beat_cnt      <= '0;
      rr_ptr        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= acc;
      if (acc) begin
        bus.rsp_id   <= sel;
        bus.rsp_sum  <= bus.add_sum;
        bus.rsp_cout <= bus.add_cout;
        bus.rsp_last <= term;
        bus.rsp_err  <= forced && !sel_last;
        owner        <= sel;
        carry_reg    <= !term && bus.add_cout;
        beat_cnt     <= term ? '0 : beat_cnt + 8'd1;
        if (term) rr_ptr <= !sel;
      end
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench with a reference arbitration/carry model
module tb_adder_share_arbiter;
  localparam int W  = 8;
  localparam int MB = 16;
  typedef struct packed {
    logic       id;
    logic [7:0] sum;
    logic       cout;
    logic       last;
    logic       err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  adder_share_arbiter_if #(.WIDTH(W)) bus();
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};
  adder_share_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_lock, m_owner, m_carry, m_rr;
  int   m_cnt;
  logic g0, g1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_carry = 0; m_rr = 0; m_cnt = 0;
    exp_q.delete();
  endtask
  task automatic cycle(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic l0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic l1,
                       output logic acc0, output logic acc1);
    logic       win, win_ok, l;
    logic [7:0] a, b;
    logic [8:0] s;
    rsp_t       r;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_last = l1;
    #1;
    win_ok = m_lock || v0 || v1;
    win    = m_lock ? m_owner : ((v0 && v1) ? m_rr : v1);
    check("ready0", bus.req0_ready, win_ok && !win);
    check("ready1", bus.req1_ready, win_ok && win);
    check("add_cin", bus.add_cin, m_carry);
    acc0 = win_ok && !win && v0;
    acc1 = win_ok && win && v1;
    if (acc0 || acc1) begin
      a = win ? a1 : a0;
      b = win ? b1 : b0;
      l = win ? l1 : l0;
      s = {1'b0, a} + {1'b0, b} + {8'd0, m_carry};
      check("add_a", bus.add_a, a);
      check("add_b", bus.add_b, b);
      r.id   = win;
      r.sum  = s[7:0];
      r.cout = s[8];
      r.err  = !l && m_cnt == MB - 1;
      r.last = l || r.err;
      exp_q.push_back(r);
      if (r.last) begin
        m_lock = 0; m_carry = 0; m_cnt = 0; m_rr = !win;
      end else begin
        m_lock = 1; m_owner = win; m_carry = s[8]; m_cnt++;
      end
    end else if (!win_ok) begin
      check("idle_add_a", bus.add_a, 0);
      check("idle_add_b", bus.add_b, 0);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_id", bus.rsp_id, r.id);
      check("rsp_sum", bus.rsp_sum, r.sum);
      check("rsp_cout", bus.rsp_cout, r.cout);
      check("rsp_last", bus.rsp_last, r.last);
      check("rsp_err", bus.rsp_err, r.err);
    end else
      check("rsp_quiet", bus.rsp_valid, 0);
  endtask
  task automatic beat0(input logic [7:0] a, input logic [7:0] b, input logic l);
    cycle(1, a, b, l, 0, 0, 0, 0, g0, g1);
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
  endtask
  initial begin
    int i0, i1, grants;
    rst_n = 0;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_last = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_sum", bus.rsp_sum, 0);
    check("rst_ready0", bus.req0_ready, 0);
    rst_n = 1;
    idle();
    // single beat
    beat0(8'h3C, 8'h05, 1);
    check("t1_sum", bus.rsp_sum, 8'h41);
    // two-beat carry chain 0x01FF + 0x0001
    beat0(8'hFF, 8'h01, 0);
    check("t2_cout0", bus.rsp_cout, 1);
    beat0(8'h01, 8'h00, 1);
    check("t2_sum1", bus.rsp_sum, 8'h02);
    // both requesters busy, 2-beat transactions, strict alternation
    i0 = 0; i1 = 0; grants = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1, 8'($urandom), 8'($urandom), i0[0], 1, 8'($urandom), 8'($urandom), i1[0], g0, g1);
      if (g0) i0++;
      if (g1) i1++;
      if (g0 || g1) grants++;
    end
    check("rr_grants", grants, 12);
    check("rr_balance", i0 - i1, 0);
    // forced termination at MAX_BEATS
    for (int j = 0; j < 17; j++) begin
      beat0(8'hFF, 8'h00, j == 16);
      if (j == 15) begin
        check("force_last", bus.rsp_last, 1);
        check("force_err", bus.rsp_err, 1);
      end
      if (j == 16) begin
        check("after_force_last", bus.rsp_last, 1);
        check("after_force_err", bus.rsp_err, 0);
      end
    end
    idle();
    // owner stalls while the other requester waits
    beat0(8'h80, 8'h80, 0);
    repeat (3) cycle(0, 0, 0, 0, 1, 8'h11, 8'h22, 1, g0, g1);
    cycle(1, 8'h00, 8'h00, 1, 1, 8'h11, 8'h22, 1, g0, g1);
    check("stall_sum", bus.rsp_sum, 8'h01);
    idle();
    idle();
    // reset mid-transaction with carry pending
    beat0(8'h80, 8'h80, 0);
    rst_n = 0;
    #1;
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check("rst_mid_ready0", bus.req0_ready, 0);
    check("rst_mid_ready1", bus.req1_ready, 0);
    model_reset();
    bus.req0_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle(0, 0, 0, 0, 1, 8'h01, 8'h01, 1, g0, g1);
    check("post_rst_sum", bus.rsp_sum, 8'h02);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
